// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer: T-state counter, program counter and instruction register,
// with memory wait-state stall and a RUN/HALTED run-control state.
module cpu_sequencer #(
  parameter int                ADDR_W    = 16,
  parameter int                T_W       = 3,
  parameter int                T_MAX     = 7,
  parameter int                FETCH_T   = 2,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] bus_in,
  input  logic              ii,
  input  logic              rt,
  input  logic              pp,
  input  logic              jmp,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              halt,
  input  logic              run,
  output logic [T_W-1:0]    t,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] ir,
  output logic              fetch,
  output logic              stall,
  output logic              halted
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam logic [T_W-1:0] T_LAST  = T_W'(T_MAX);
  localparam logic [T_W-1:0] T_FETCH = T_W'(FETCH_T);

  state_t            state, state_next;
  logic [T_W-1:0]    t_next;
  logic [ADDR_W-1:0] pc_next, ir_next;

  // A halted sequencer never waits on memory, so stall is qualified by RUN.
  assign stall  = mem_req & ~mem_ready & (state == RUN);
  assign fetch  = (t < T_FETCH);
  assign halted = (state == HALTED);

  // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    t_next     = t;
    pc_next    = pc;
    ir_next    = ir;
    unique case (state)
      RUN: begin
        if (!stall) begin
          if (ii) ir_next = bus_in;
          if (jmp)     pc_next = bus_in;
          else if (pp) pc_next = pc + ADDR_W'(1);
          // Halt parks the counter at T0 so the resumed program starts with a fetch.
          if (rt || halt || t == T_LAST) t_next = '0;
          else                           t_next = t + T_W'(1);
          if (halt) state_next = HALTED;
        end
      end
      HALTED: begin
        if (run) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      t     <= '0;
      pc    <= RESET_VEC;
      ir    <= '0;
    end else begin
      state <= state_next;
      t     <= t_next;
      pc    <= pc_next;
      ir    <= ir_next;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus randomized control
// traffic compared every cycle against a behavioural model of the sequencing rules.
module tb_cpu_sequencer;

  localparam int          T_MAX   = 7;
  localparam int          FETCH_T = 2;
  localparam logic [15:0] RV      = 16'h0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bus_in;
  logic        ii, rt, pp, jmp, mem_req, mem_ready, halt, run;
  logic [2:0]  t;
  logic [15:0] pc, ir;
  logic        fetch, stall, halted;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: plain integers following the sequencing rules.
  int m_t, m_pc, m_ir;
  bit m_halted;

  cpu_sequencer #(
    .ADDR_W(16), .T_W(3), .T_MAX(T_MAX), .FETCH_T(FETCH_T), .RESET_VEC(RV)
  ) dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .ii(ii), .rt(rt), .pp(pp), .jmp(jmp),
    .mem_req(mem_req), .mem_ready(mem_ready), .halt(halt), .run(run),
    .t(t), .pc(pc), .ir(ir), .fetch(fetch), .stall(stall), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (time %0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    bus_in = '0; ii = 0; rt = 0; pp = 0; jmp = 0;
    mem_req = 0; mem_ready = 0; halt = 0; run = 0;
  endtask

  task automatic model_reset();
    m_t = 0; m_pc = int'(RV); m_ir = 0; m_halted = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_t"},      32'(t),      32'(m_t));
    check({tag, "_pc"},     32'(pc),     32'(m_pc));
    check({tag, "_ir"},     32'(ir),     32'(m_ir));
    check({tag, "_halted"}, 32'(halted), 32'(m_halted));
  endtask

  // One clock: inputs already driven after the previous falling edge.
  task automatic tick(input string tag);
    bit waiting;
    #1;
    waiting = mem_req && !mem_ready && !m_halted;
    check({tag, "_fetch"}, 32'(fetch), 32'(m_t < FETCH_T));
    check({tag, "_stall"}, 32'(stall), 32'(waiting));
    @(posedge clk);
    if (m_halted) begin
      if (run) m_halted = 0;
    end else if (!waiting) begin
      if (ii) m_ir = int'(bus_in);
      if (jmp)     m_pc = int'(bus_in);
      else if (pp) m_pc = (m_pc + 1) % 65536;
      m_t = (rt || halt) ? 0 : (m_t + 1) % (T_MAX + 1);
      if (halt) m_halted = 1;
    end
    @(negedge clk);
    check_regs(tag);
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    #1;
    check_regs("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    idle();
  endtask

  task automatic run_to_t(input int k);
    idle();
    for (int n = 0; n < 2 * (T_MAX + 1) && m_t != k; n++) tick("seek");
    check("seek_reached", 32'(t), 32'(k));
  endtask

  initial begin
    idle();
    reset = 1;
    model_reset();
    #1;
    check_regs("por");
    @(negedge clk);
    reset = 0;

    // pp on each T0: pc steps once per microcode cycle, t walks 0..7 and wraps.
    for (int n = 0; n < 2 * (T_MAX + 1); n++) begin
      idle();
      pp = (m_t == 0);
      tick("tcycle");
    end
    check("pc_third_t0", 32'(pc), 32'h0102);
    check("t_after_two_cycles", 32'(t), 32'd0);

    // PC wrap and jump-over-increment priority.
    idle(); jmp = 1; bus_in = 16'hFFFF; tick("jmp_ffff");
    idle(); pp = 1; tick("pc_wrap");
    check("pc_wrap_zero", 32'(pc), 32'h0000);
    idle(); pp = 1; jmp = 1; bus_in = 16'h1234; tick("jmp_beats_pp");
    check("pc_jmp_1234", 32'(pc), 32'h1234);

    // Wait-state stall at t=3 freezes everything, then completes.
    run_to_t(3);
    for (int n = 0; n < 4; n++) begin
      idle(); mem_req = 1; ii = 1; pp = 1; bus_in = 16'h5A5A; tick("stall");
    end
    check("stall_t_held", 32'(t), 32'd3);
    idle(); mem_req = 1; mem_ready = 1; ii = 1; pp = 1; bus_in = 16'h5A5A; tick("ready");
    check("ready_t", 32'(t), 32'd4);
    check("ready_ir", 32'(ir), 32'h5A5A);
    check("ready_pc", 32'(pc), 32'h1235);

    // rt at t=2, natural wrap at T_MAX, rt at T0.
    run_to_t(2);
    idle(); rt = 1; tick("rt_t2");
    check("rt_t2_zero", 32'(t), 32'd0);
    idle(); rt = 1; tick("rt_t0");
    check("rt_t0_zero", 32'(t), 32'd0);
    run_to_t(T_MAX);
    idle(); tick("tmax_wrap");
    check("tmax_wrap_zero", 32'(t), 32'd0);

    // Halt at t=4 while loading IR; control ignored while halted; resume.
    run_to_t(4);
    idle(); halt = 1; ii = 1; bus_in = 16'hABCD; tick("halt");
    check("halt_ir", 32'(ir), 32'hABCD);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_t", 32'(t), 32'd0);
    for (int n = 0; n < 10; n++) begin
      idle(); pp = 1; jmp = 1; ii = 1; mem_req = 1; rt = 1; bus_in = 16'(n + 7); tick("halted_hold");
    end
    idle(); run = 1; halt = 1; tick("resume");
    check("resume_flag", 32'(halted), 32'd0);
    check("resume_t", 32'(t), 32'd0);
    idle(); tick("resume_step");
    check("resume_t1", 32'(t), 32'd1);

    // Asynchronous reset in the middle of a stall at t=5.
    run_to_t(5);
    idle(); mem_req = 1; tick("pre_reset_stall");
    reset = 1;
    #1;
    check("areset_t", 32'(t), 32'd0);
    check("areset_pc", 32'(pc), 32'(RV));
    check("areset_ir", 32'(ir), 32'd0);
    check("areset_halted", 32'(halted), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 0;
    idle();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        bus_in    = 16'($urandom);
        ii        = ($urandom_range(0, 2) == 0);
        rt        = ($urandom_range(0, 7) == 0);
        pp        = ($urandom_range(0, 2) == 0);
        jmp       = ($urandom_range(0, 5) == 0);
        mem_req   = ($urandom_range(0, 2) == 0);
        mem_ready = ($urandom_range(0, 1) == 0);
        halt      = ($urandom_range(0, 19) == 0);
        run       = ($urandom_range(0, 3) == 0);
        tick("rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
